// File: rtl/ahb_pkg.sv
// ----------------------------------------------------------------------------
// ahb_pkg
// Shared AHB-Lite definitions for the SRAM slave and its memory array:
// transfer-type encoding, response codes, transfer-size codes and the
// byte-lane mask helper used when committing sub-word writes.
// ----------------------------------------------------------------------------
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        NONSEQ = 2'd2,
        SEQ    = 2'd3
    } htrans_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    // Byte lanes touched by a transfer of the given size at the given
    // low address bits (little-endian, 32-bit bus).
    function automatic logic [3:0] lane_mask(input logic [2:0] size,
                                             input logic [1:0] addr_lo);
        logic [3:0] mask;
        case (size)
            HSIZE_BYTE: mask = 4'b0001 << addr_lo;
            HSIZE_HALF: mask = 4'b0011 << {addr_lo[1], 1'b0};
            HSIZE_WORD: mask = 4'b1111;
            default:    mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/ahb_sram_mem.sv
// ----------------------------------------------------------------------------
// ahb_sram_mem
// Byte-lane-writable word array. Writes are synchronous, reads are
// asynchronous so the data phase can present the word directly. Contents
// are deliberately not reset.
//
// Ports:
//   hclk      clock
//   we_i      write enable (commits on the rising edge)
//   wr_idx_i  word index to write
//   lane_i    per-byte write enables
//   wdata_i   write data
//   rd_idx_i  word index to read
//   rdata_o   read data (combinational)
// ----------------------------------------------------------------------------
module ahb_sram_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024,
    parameter int IDX_W      = $clog2(MEM_DEPTH)
) (
    input  logic                    hclk,
    input  logic                    we_i,
    input  logic [IDX_W-1:0]        wr_idx_i,
    input  logic [DATA_WIDTH/8-1:0] lane_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [IDX_W-1:0]        rd_idx_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    always_ff @(posedge hclk) begin
        if (we_i) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (lane_i[b]) begin
                    mem_q[wr_idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[rd_idx_i];

endmodule

// File: rtl/ahb_sram_slave.sv
// ----------------------------------------------------------------------------
// ahb_sram_slave
// AHB-Lite slave terminating word/half/byte traffic into an on-chip SRAM.
// Inserts WAIT_STATES wait cycles per data phase and answers illegal
// accesses (out of window, hsize > word, misaligned) with a two-cycle
// ERROR response without touching memory.
//
// State table:
//   S_IDLE | no pending data phase, OKAY, ready
//   S_WAIT | wait states, counter runs WAIT_STATES..1, not ready
//   S_DATA | last data-phase cycle; read data driven / write commits at end
//   S_ERR1 | first ERROR cycle, not ready
//   S_ERR2 | second ERROR cycle, ready
//
// Ports:
//   hclk, hresetn          clock, async active-low reset
//   hsel, hready           slave select, bus-wide ready
//   haddr, htrans, hwrite  address-phase controls
//   hsize, hburst          transfer size; burst type (ignored)
//   hwdata, hwstrb         data-phase write data and byte strobes
//   hreadyout, hresp       slave ready and response
//   hrdata                 read data (zero outside a read S_DATA)
// ----------------------------------------------------------------------------
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int                     HADDR_WIDTH = 32,
    parameter int                     DATA_WIDTH  = 32,
    parameter int                     MEM_DEPTH   = 1024,
    parameter logic [HADDR_WIDTH-1:0] BASE_ADDR   = 32'h2000_0000,
    parameter int                     WAIT_STATES = 0
) (
    input  logic                    hclk,
    input  logic                    hresetn,
    input  logic                    hsel,
    input  logic                    hready,
    input  logic [HADDR_WIDTH-1:0]  haddr,
    input  logic [1:0]              htrans,
    input  logic                    hwrite,
    input  logic [2:0]              hsize,
    input  logic [2:0]              hburst,
    input  logic [DATA_WIDTH-1:0]   hwdata,
    input  logic [DATA_WIDTH/8-1:0] hwstrb,
    output logic                    hreadyout,
    output logic                    hresp,
    output logic [DATA_WIDTH-1:0]   hrdata
);

    localparam int         IDX_W = $clog2(MEM_DEPTH);
    localparam logic [1:0] WS_L  = 2'(WAIT_STATES);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_ERR1 = 3'd3;
    localparam logic [2:0] S_ERR2 = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [IDX_W+1:0] addr_q, addr_d;
    logic             write_q, write_d;
    logic [2:0]       size_q, size_d;

    logic [HADDR_WIDTH-1:0] offset;
    logic                   in_range;
    logic                   size_ok;
    logic                   aligned;
    logic                   legal;
    logic                   can_accept;
    logic                   is_active;
    logic                   accept;

    logic                    mem_we;
    logic [3:0]              mem_lane;
    logic [DATA_WIDTH-1:0]   mem_rdata;

    // Burst type carries no information for this slave.
    logic unused_hburst;
    assign unused_hburst = ^hburst;

    // Error decode on the live address phase. The window check uses the
    // offset from BASE_ADDR so it cannot wrap at the top of address space.
    assign offset   = haddr - BASE_ADDR;
    assign in_range = (haddr >= BASE_ADDR) && ((offset >> (IDX_W + 2)) == '0);
    assign size_ok  = (hsize <= HSIZE_WORD);

    always_comb begin
        aligned = 1'b1;
        case (hsize)
            HSIZE_HALF: aligned = ~haddr[0];
            HSIZE_WORD: aligned = (haddr[1:0] == 2'b00);
            default:    aligned = 1'b1;
        endcase
    end

    assign legal      = in_range && size_ok && aligned;
    assign is_active  = (htrans_t'(htrans) == NONSEQ) || (htrans_t'(htrans) == SEQ);
    // During S_WAIT/S_ERR1 the bus hready is low anyway; gating here keeps
    // a stray address phase in ERR1 from being taken.
    assign can_accept = (state_q == S_IDLE) || (state_q == S_DATA) || (state_q == S_ERR2);
    assign accept     = hsel && hready && is_active && can_accept;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;

        if (accept) begin
            addr_d  = offset[IDX_W+1:0];
            write_d = hwrite;
            size_d  = hsize;
            if (!legal) begin
                state_d = S_ERR1;
            end else if (WAIT_STATES > 0) begin
                state_d = S_WAIT;
                cnt_d   = WS_L;
            end else begin
                state_d = S_DATA;
            end
        end else begin
            case (state_q)
                S_IDLE: state_d = S_IDLE;
                S_WAIT: begin
                    if (cnt_q <= 2'd1) begin
                        state_d = S_DATA;
                        cnt_d   = 2'd0;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
                S_DATA: state_d = S_IDLE;
                S_ERR1: state_d = S_ERR2;
                S_ERR2: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
        end
    end

    // The write lands on the edge that closes S_DATA, so a read whose
    // address phase overlaps this data phase already sees the new word.
    assign mem_we   = (state_q == S_DATA) && write_q;
    assign mem_lane = lane_mask(size_q, addr_q[1:0]) & hwstrb;

    ahb_sram_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .IDX_W      (IDX_W)
    ) u_mem (
        .hclk     (hclk),
        .we_i     (mem_we),
        .wr_idx_i (addr_q[IDX_W+1:2]),
        .lane_i   (mem_lane),
        .wdata_i  (hwdata),
        .rd_idx_i (addr_q[IDX_W+1:2]),
        .rdata_o  (mem_rdata)
    );

    assign hreadyout = !((state_q == S_WAIT) || (state_q == S_ERR1));
    assign hresp     = ((state_q == S_ERR1) || (state_q == S_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign hrdata    = ((state_q == S_DATA) && !write_q) ? mem_rdata : '0;

endmodule
